// File: rtl/hamming_enc_seq.sv
// Hamming (16,11) SECDED encode sequencer over the shared byte-wide data-memory port.
// Optional HAMMING_READBACK_EN adds a per-message readback/compare with a saturating mismatch counter.
module hamming_enc_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic          busy,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    err_cnt
);

    // state | meaning
    // IDLE  | waiting for first req after reset
    // RD_LO | read message low byte d[8:1]
    // RD_HI | read message high byte d[11:9]
    // CALC  | load codeword register from captured bytes
    // WR_LO | write cw[7:0]
    // WR_HI | write cw[15:8], then next message or DONE
    // DONE  | job complete, done held until next req
    // RB_LO | read back cw[7:0] (readback build only)
    // RB_HI | read back cw[15:8] (readback build only)
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RD_LO = 4'd1,
        RD_HI = 4'd2,
        CALC  = 4'd3,
        WR_LO = 4'd4,
        WR_HI = 4'd5,
        DONE  = 4'd6,
        RB_LO = 4'd7,
        RB_HI = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        TAG_LO    = 2'd0,
        TAG_HI    = 2'd1,
        TAG_RB_LO = 2'd2,
        TAG_RB_HI = 2'd3
    } tag_t;

    state_t        state_q, state_d;
    logic [6:0]    idx_q, idx_d;
    logic          req_q;
    logic          rd_vld;
    tag_t          rd_tag, rd_tag_d;
    logic [7:0]    lo_byte;
    logic [2:0]    hi_bits;
    logic [2:0]    hi_eff;
    logic [15:0]   cw_q;
    logic          rd_strobe;
    logic          last_msg;
    logic [AW-1:0] src_lo, src_hi, dst_lo, dst_hi;

    function automatic logic [15:0] encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    assign src_lo   = AW'(SRC_BASE + 2 * int'(idx_q));
    assign src_hi   = AW'(SRC_BASE + 2 * int'(idx_q) + 1);
    assign dst_lo   = AW'(DST_BASE + 2 * int'(idx_q));
    assign dst_hi   = AW'(DST_BASE + 2 * int'(idx_q) + 1);
    assign last_msg = (idx_q == 7'(NUM_MSG - 1));

    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign rd_strobe = mem_req && mem_gnt && !mem_we;

    // The high-byte read lands on the same edge CALC loads the codeword, so take it straight off the bus.
    assign hi_eff = (rd_vld && rd_tag == TAG_HI) ? mem_rdata[2:0] : hi_bits;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_tag_d  = TAG_LO;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE, DONE: begin
                if (req_q) begin
                    idx_d   = '0;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                mem_req  = 1'b1;
                mem_addr = src_lo;
                rd_tag_d = TAG_LO;
                if (mem_gnt) state_d = RD_HI;
            end
            RD_HI: begin
                mem_req  = 1'b1;
                mem_addr = src_hi;
                rd_tag_d = TAG_HI;
                if (mem_gnt) state_d = CALC;
            end
            CALC: begin
                state_d = WR_LO;
            end
            WR_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_lo;
                mem_wdata = cw_q[7:0];
                if (mem_gnt) state_d = WR_HI;
            end
            WR_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_hi;
                mem_wdata = cw_q[15:8];
                if (mem_gnt) begin
`ifdef HAMMING_READBACK_EN
                    state_d = RB_LO;
`else
                    if (last_msg) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = RD_LO;
                    end
`endif
                end
            end
`ifdef HAMMING_READBACK_EN
            RB_LO: begin
                mem_req  = 1'b1;
                mem_addr = dst_lo;
                rd_tag_d = TAG_RB_LO;
                if (mem_gnt) state_d = RB_HI;
            end
            RB_HI: begin
                mem_req  = 1'b1;
                mem_addr = dst_hi;
                rd_tag_d = TAG_RB_HI;
                if (mem_gnt) begin
                    if (last_msg) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = RD_LO;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            rd_vld  <= 1'b0;
            rd_tag  <= TAG_LO;
            lo_byte <= '0;
            hi_bits <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req;
            rd_vld  <= rd_strobe;
            if (rd_strobe) rd_tag <= rd_tag_d;
            if (rd_vld && rd_tag == TAG_LO) lo_byte <= mem_rdata;
            if (rd_vld && rd_tag == TAG_HI) hi_bits <= mem_rdata[2:0];
            if (state_q == CALC) cw_q <= encode({hi_eff, lo_byte});
        end
    end

`ifdef HAMMING_READBACK_EN
    logic       accept;
    logic       rb_cmp;
    logic [7:0] rb_exp;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && req_q;
    assign rb_exp = (rd_tag == TAG_RB_LO) ? cw_q[7:0] : cw_q[15:8];
    // The final RB_HI byte is compared on the first edge in DONE; cw_q is still valid then.
    assign rb_cmp = rd_vld && ((rd_tag == TAG_RB_LO) || (rd_tag == TAG_RB_HI));

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (rb_cmp && (mem_rdata != rb_exp) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule
